state_ball: RTL and testbench

- Ball motion stage on the pong playfield grid; consumes the paddle's left-edge column from the paddle state stage.
- Advances the ball one cell diagonally per step tick, reflects off the side walls and the top wall, and checks for a paddle hit on the bottom row.
- Produces ball coordinates for the display stage, hit/miss pulses and a rally score.

---
 rtl/pong_pkg.sv | 24 ++
 rtl/state_ball_tick_gen.sv | 41 ++++
 rtl/state_ball.sv | 198 +++++++++++++++++++
 tb/tb_state_ball.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong pipeline stages: FSM and direction
// encodings plus the grid geometry the paddle and ball stages must agree on.
package pong_pkg;

    // Default playfield geometry shared by the paddle and ball stages.
    localparam int GRID_BIT_WIDTH = 3;
    localparam int GRID_ROW_BITS  = 3;
    localparam int PADDLE_SIZE    = 2;

    // Ball stage FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        MOVE  = 2'd2,
        MISS  = 2'd3
    } state_t;

    // Direction of travel along one axis (POS = right / down).
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

endpackage

// File: rtl/state_ball_tick_gen.sv
// Step prescaler: counts 0..TICK-1 while run is high and raises step during
// the cycle the count sits at TICK-1. Dropping run clears the count at once.
module tick_gen #(
    parameter int TICK      = 12500000,
    parameter int TICK_BITS = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic step
);

    localparam logic [TICK_BITS-1:0] TICK_LAST = TICK_BITS'(TICK - 1);

    logic [TICK_BITS-1:0] cnt_q;
    logic [TICK_BITS-1:0] cnt_d;

    // Next count: wrap at TICK-1, forced to zero while not running.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == TICK_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step = run && (cnt_q == TICK_LAST);

endmodule

// File: rtl/state_ball.sv
// Ball motion stage: moves the ball one diagonal cell per step, reflects off
// the side and top walls, scores paddle returns and flags misses.
// There is no handshake: paddle_left is sampled in the step cycle, and all
// outputs are registered, updating one clk after the step cycle.
// dbg_state mirrors the FSM register for observation.
module state_ball
    import pong_pkg::*;
#(
    parameter int BIT_WIDTH  = GRID_BIT_WIDTH,
    parameter int ROW_BITS   = GRID_ROW_BITS,
    parameter int SIZE       = PADDLE_SIZE,
    parameter int SERVE_X    = 3,
    parameter int TICK       = 12500000,
    parameter int TICK_BITS  = 24,
    parameter int SCORE_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [BIT_WIDTH-1:0]  paddle_left,
    output logic [BIT_WIDTH-1:0]  ball_x,
    output logic [ROW_BITS-1:0]   ball_y,
    output logic                  hit,
    output logic                  miss,
    output logic [SCORE_BITS-1:0] score,
    output logic [1:0]            dbg_state
);

    localparam logic [BIT_WIDTH-1:0]  MAX_X     = '1;
    localparam logic [ROW_BITS-1:0]   MAX_Y     = '1;
    localparam logic [BIT_WIDTH-1:0]  X_SERVE   = BIT_WIDTH'(SERVE_X);
    localparam logic [SCORE_BITS-1:0] SCORE_MAX = '1;
    localparam logic [BIT_WIDTH:0]    SPAN      = (BIT_WIDTH + 1)'(SIZE - 1);

    state_t                state_q, state_d;
    logic [BIT_WIDTH-1:0]  x_q, x_d;
    logic [ROW_BITS-1:0]   y_q, y_d;
    dir_t                  dx_q, dx_d;
    dir_t                  dy_q, dy_d;
    logic [SCORE_BITS-1:0] score_q, score_d;
    logic                  hit_q, hit_d;
    logic                  miss_q, miss_d;

    logic                  step;
    logic                  run;
    logic [BIT_WIDTH-1:0]  x_step;
    dir_t                  dx_step;
    logic [BIT_WIDTH:0]    x_ext;
    logic [BIT_WIDTH:0]    pl_ext;
    logic                  paddle_hit;

    // The prescaler only runs in an active state with the game enabled, so
    // dropping en also suppresses a step landing in the same cycle.
    assign run = (state_q != IDLE) && en;

    tick_gen #(
        .TICK      (TICK),
        .TICK_BITS (TICK_BITS)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .step (step)
    );

    // Paddle coverage compared one bit wider so the right edge never wraps.
    assign x_ext      = {1'b0, x_q};
    assign pl_ext     = {1'b0, paddle_left};
    assign paddle_hit = (x_ext >= pl_ext) && (x_ext <= pl_ext + SPAN);

    // Horizontal move with side-wall reflection.
    always_comb begin
        x_step  = x_q;
        dx_step = dx_q;
        if (dx_q == DIR_POS) begin
            if (x_q == MAX_X) begin
                x_step  = MAX_X - 1'b1;
                dx_step = DIR_NEG;
            end else begin
                x_step = x_q + 1'b1;
            end
        end else begin
            if (x_q == '0) begin
                x_step  = BIT_WIDTH'(1);
                dx_step = DIR_POS;
            end else begin
                x_step = x_q - 1'b1;
            end
        end
    end

    // Next-state, vertical move, paddle check and pulse generation.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        score_d = score_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
            x_d     = X_SERVE;
            y_d     = '0;
            dx_d    = DIR_POS;
            dy_d    = DIR_POS;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SERVE;
                    x_d     = X_SERVE;
                    y_d     = '0;
                    dx_d    = DIR_POS;
                    dy_d    = DIR_POS;
                end
                SERVE: begin
                    if (step) begin
                        state_d = MOVE;
                    end
                end
                MOVE: begin
                    if (step) begin
                        if (dy_q == DIR_NEG && y_q == '0) begin
                            y_d  = ROW_BITS'(1);
                            dy_d = DIR_POS;
                            x_d  = x_step;
                            dx_d = dx_step;
                        end else if (dy_q == DIR_POS && y_q == MAX_Y - 1'b1) begin
                            if (paddle_hit) begin
                                y_d   = MAX_Y - ROW_BITS'(2);
                                dy_d  = DIR_NEG;
                                x_d   = x_step;
                                dx_d  = dx_step;
                                hit_d = 1'b1;
                                if (score_q != SCORE_MAX) begin
                                    score_d = score_q + 1'b1;
                                end
                            end else begin
                                y_d     = MAX_Y;
                                miss_d  = 1'b1;
                                state_d = MISS;
                            end
                        end else begin
                            y_d  = (dy_q == DIR_POS) ? y_q + 1'b1 : y_q - 1'b1;
                            x_d  = x_step;
                            dx_d = dx_step;
                        end
                    end
                end
                MISS: begin
                    if (step) begin
                        score_d = '0;
                        x_d     = X_SERVE;
                        y_d     = '0;
                        dx_d    = DIR_POS;
                        dy_d    = DIR_POS;
                        state_d = SERVE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= X_SERVE;
            y_q     <= '0;
            dx_q    <= DIR_POS;
            dy_q    <= DIR_POS;
            score_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            score_q <= score_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign score     = score_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_state_ball.sv
// Bench for state_ball: two instances (serve columns 3 and 2) share inputs
// and are checked every cycle against a grid-level motion model, plus
// literal expectations at chosen points of directed rallies.
module tb_state_ball;
    import pong_pkg::*;

    localparam int TK   = 4;
    localparam int MAXX = 7;
    localparam int MAXY = 7;
    localparam int SZ   = 2;
    localparam int SMAX = 15;

    // ---------------- clock / reset / DUTs ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [2:0] pl  = 3'd0;

    logic [2:0] bx [2];
    logic [2:0] by [2];
    logic       hw [2];
    logic       mw [2];
    logic [3:0] sc [2];
    logic [1:0] st [2];

    always #5 clk = ~clk;

    state_ball #(.BIT_WIDTH(3), .ROW_BITS(3), .SIZE(2), .SERVE_X(3),
                 .TICK(TK), .TICK_BITS(3), .SCORE_BITS(4)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .paddle_left(pl),
        .ball_x(bx[0]), .ball_y(by[0]), .hit(hw[0]), .miss(mw[0]),
        .score(sc[0]), .dbg_state(st[0])
    );

    state_ball #(.BIT_WIDTH(3), .ROW_BITS(3), .SIZE(2), .SERVE_X(2),
                 .TICK(TK), .TICK_BITS(3), .SCORE_BITS(4)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .paddle_left(pl),
        .ball_x(bx[1]), .ball_y(by[1]), .hit(hw[1]), .miss(mw[1]),
        .score(sc[1]), .dbg_state(st[1])
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Ball kept as signed integer position and +/-1 velocity per axis.
    int     serve_x [2] = '{3, 2};
    state_t m_mode  [2];
    int     m_x [2], m_y [2], m_dx [2], m_dy [2], m_score [2], m_cnt [2];
    bit     m_hit [2], m_miss [2], m_step [2];

    task automatic model_serve(input int i);
        m_x[i]  = serve_x[i];
        m_y[i]  = 0;
        m_dx[i] = 1;
        m_dy[i] = 1;
    endtask

    task automatic model_edge(input int i);
        bit s;
        int nx, ndx, ny, ndy, p;
        m_hit[i]  = 1'b0;
        m_miss[i] = 1'b0;
        m_step[i] = 1'b0;
        p = int'(pl);
        if (rst) begin
            m_mode[i]  = IDLE;
            m_score[i] = 0;
            m_cnt[i]   = 0;
            model_serve(i);
        end else if (!en) begin
            m_mode[i] = IDLE;
            m_cnt[i]  = 0;
            model_serve(i);
        end else begin
            s         = (m_mode[i] != IDLE) && (m_cnt[i] == TK - 1);
            m_step[i] = s;
            m_cnt[i]  = (m_mode[i] == IDLE) ? 0 : (m_cnt[i] + 1) % TK;
            case (m_mode[i])
                IDLE:  m_mode[i] = SERVE;
                SERVE: if (s) m_mode[i] = MOVE;
                MOVE: if (s) begin
                    nx = m_x[i] + m_dx[i];
                    ndx = m_dx[i];
                    if (nx < 0) begin nx = 1; ndx = 1; end
                    else if (nx > MAXX) begin nx = MAXX - 1; ndx = -1; end
                    ny = m_y[i] + m_dy[i];
                    ndy = m_dy[i];
                    if (ny < 0) begin ny = 1; ndy = 1; end
                    else if (ny == MAXY) begin
                        if (m_x[i] >= p && m_x[i] <= p + SZ - 1) begin
                            ny = MAXY - 2;
                            ndy = -1;
                            m_hit[i] = 1'b1;
                            m_score[i] = (m_score[i] < SMAX) ? m_score[i] + 1 : SMAX;
                        end else begin
                            nx = m_x[i];
                            ndx = m_dx[i];
                            m_miss[i] = 1'b1;
                            m_mode[i] = MISS;
                        end
                    end
                    m_x[i] = nx; m_dx[i] = ndx; m_y[i] = ny; m_dy[i] = ndy;
                end
                MISS: if (s) begin
                    m_score[i] = 0;
                    model_serve(i);
                    m_mode[i] = SERVE;
                end
                default: m_mode[i] = IDLE;
            endcase
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_edge(i);
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("x[%0d]", i), bx[i], m_x[i]);
                chk($sformatf("y[%0d]", i), by[i], m_y[i]);
                chk($sformatf("hit[%0d]", i), hw[i], int'(m_hit[i]));
                chk($sformatf("miss[%0d]", i), mw[i], int'(m_miss[i]));
                chk($sformatf("score[%0d]", i), sc[i], m_score[i]);
                chk($sformatf("state[%0d]", i), st[i], int'(m_mode[i]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Returns at the negedge following the next step edge (bounded).
    task automatic next_step();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!m_step[0] && k < 40);
        if (!m_step[0]) chk("step_wait", 0, 1);
    endtask

    task automatic lit_pos(input string name, input int i, input int x, input int y);
        chk({name, "_x"}, bx[i], x);
        chk({name, "_y"}, by[i], y);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int path_a [12][2] = '{'{4,1}, '{5,2}, '{6,3}, '{7,4}, '{6,5}, '{5,6},
                            '{4,5}, '{3,4}, '{2,3}, '{1,2}, '{0,1}, '{1,0}};
    int path_b [5][2]  = '{'{3,2}, '{4,3}, '{5,4}, '{6,5}, '{7,6}};

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int r;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Idle with en low: ball parked at serve.
        repeat (20) @(negedge clk);
        lit_pos("idle", 0, 3, 0);
        chk("idle_state", st[0], int'(IDLE));
        chk("idle_score", sc[0], 0);

        // Rally with paddle at 4: right-wall bounce, hit, top-wall bounce.
        en = 1'b1;
        pl = 3'd4;
        next_step();
        lit_pos("serve_step", 0, 3, 0);
        chk("serve_step_state", st[0], int'(MOVE));
        for (int s = 0; s < 12; s++) begin
            next_step();
            lit_pos($sformatf("path_a%0d", s), 0, path_a[s][0], path_a[s][1]);
            if (s == 6) begin
                chk("first_hit", hw[0], 1);
                chk("first_hit_score", sc[0], 1);
            end
        end
        next_step();
        lit_pos("top_bounce", 0, 2, 1);

        // Right-corner return with paddle at 6 for a second point.
        pl = 3'd6;
        for (int s = 0; s < 5; s++) begin
            next_step();
            lit_pos($sformatf("path_b%0d", s), 0, path_b[s][0], path_b[s][1]);
        end
        next_step();
        lit_pos("corner_hit", 0, 6, 5);
        chk("corner_hit_pulse", hw[0], 1);
        chk("score_two", sc[0], 2);

        // One cycle of en low: back to idle, score held.
        en = 1'b0;
        @(negedge clk);
        lit_pos("en_low", 0, 3, 0);
        chk("en_low_state", st[0], int'(IDLE));
        chk("en_low_score", sc[0], 2);
        en = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (st[0] != MOVE && k < 20);
        chk("serve_latency", k, 1 + TK);

        // Miss with paddle at 0, then re-serve clears score.
        pl = 3'd0;
        for (int s = 0; s < 7; s++) next_step();
        lit_pos("miss", 0, 5, 7);
        chk("miss_pulse", mw[0], 1);
        chk("miss_score", sc[0], 2);
        next_step();
        lit_pos("reserve", 0, 3, 0);
        chk("reserve_score", sc[0], 0);
        chk("reserve_state", st[0], int'(SERVE));

        // Reset asserted in a step cycle mid-MOVE.
        pl = 3'd4;
        for (int s = 0; s < 8; s++) next_step();
        k = 0;
        while (!(m_mode[0] == MOVE && m_cnt[0] == TK - 1) && k < 20) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lit_pos("mid_rst", 0, 3, 0);
        chk("mid_rst_score", sc[0], 0);
        chk("mid_rst_hit", hw[0], 0);
        chk("mid_rst_state", st[0], int'(IDLE));

        // Corner (0,0) moving up-left on the serve-column-2 instance.
        pulse_rst();
        pl = 3'd5;
        for (int s = 0; s < 13; s++) next_step();
        lit_pos("corner00", 1, 0, 0);
        next_step();
        lit_pos("corner11", 1, 1, 1);
        next_step();
        lit_pos("corner22", 1, 2, 2);

        // Perfect tracking: score must saturate.
        pulse_rst();
        for (int c = 0; c < 1400; c++) begin
            @(negedge clk);
            pl = 3'((m_x[0] > MAXX - SZ + 1) ? MAXX - SZ + 1 : m_x[0]);
        end
        chk("saturate", sc[0], SMAX);

        // Randomised play with occasional en drops and resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r   = $urandom_range(0, 3);
            pl  = (r == 0) ? 3'($urandom_range(0, 7))
                           : 3'((m_x[0] > MAXX - SZ + 1) ? MAXX - SZ + 1 : m_x[0]);
            en  = ($urandom_range(0, 299) != 0);
            rst = ($urandom_range(0, 1499) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
